// File: rtl/button_cmd_ctl.sv
// button_cmd_ctl: sync, debounce and edge-detect two buttons into left/right command pulses (optional BUTTON_AUTOREPEAT_EN)
module button_cmd_ctl #(
  parameter int DEBOUNCE_CYCLES = 650_000,
  parameter int REPEAT_DELAY    = 8_125_000,
  parameter int REPEAT_PERIOD   = 4_062_500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  input  logic endgame,
  output logic left,
  output logic right,
  output logic left_level,
  output logic right_level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_cmd_ctl: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end
  typedef enum logic [1:0] {IDLE, PRESSED, HOLD_DELAY, REPEAT} state_t;
  logic [1:0] s1, s2, lvl;
  logic [CW-1:0] cnt [2];
  state_t ls, ls_n, rs, rs_n;
  logic lev, rev;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [RW-1:0] rc, rc_n;
`endif
  assign left_level = lvl[0];
  assign right_level = lvl[1];
  // two-flop synchroniser; bit 0 = left, bit 1 = right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {btn_right_raw, btn_left_raw};
      s2 <= s1;
    end
  end
  // debounce: accept a level change only after an unbroken run of differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + CW'(cnt[i] != CW'(DEBOUNCE_CYCLES));
      end
    end
  end
  // state and registered, gated command outputs; left wins a same-cycle collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls <= IDLE;
      rs <= IDLE;
      left <= 1'b0;
      right <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rc <= '0;
`endif
    end else begin
      ls <= ls_n;
      rs <= rs_n;
      left <= lev & ~endgame;
      right <= rev & ~lev & ~endgame;
`ifdef BUTTON_AUTOREPEAT_EN
      rc <= rc_n;
`endif
    end
  end
  // next state and pulse events; FSMs track levels even while endgame masks outputs
  always_comb begin
    ls_n = ls;
    rs_n = rs;
    lev = 1'b0;
    rev = 1'b0;
    if (!lvl[1]) rs_n = IDLE;
    else if (rs == IDLE) begin
      rs_n = PRESSED;
      rev = 1'b1;
    end
`ifdef BUTTON_AUTOREPEAT_EN
    rc_n = rc;
    if (!lvl[0]) ls_n = IDLE;
    else if (ls == IDLE || ls == PRESSED) begin
      ls_n = HOLD_DELAY;
      lev = ls == IDLE;
      rc_n = '0;
    end else if (rc == RW'(ls == HOLD_DELAY ? REPEAT_DELAY - 1 : REPEAT_PERIOD - 1)) begin
      ls_n = REPEAT;
      lev = 1'b1;
      rc_n = '0;
    end else rc_n = rc + RW'(1);
`else
    if (!lvl[0]) ls_n = IDLE;
    else if (ls == IDLE) begin
      ls_n = PRESSED;
      lev = 1'b1;
    end
`endif
  end
endmodule
